// File: rtl/spi_eeprom_pkg.sv
// spi_eeprom_pkg
//   Shared definitions for the 25LC020A-family SPI EEPROM master:
//   the EEPROM instruction bytes, the CMD_OP encoding, the FSM state
//   encoding and helpers that turn a request into a serial frame.
package spi_eeprom_pkg;

  // EEPROM instruction bytes
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;

  // Longest frame is opcode + two bytes; the bit counter must hold 24.
  localparam int FRAME_W  = 24;
  localparam int BITCNT_W = 5;

  typedef enum logic [1:0] {
    CMD_WREN  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_RDSR  = 2'd2,
    CMD_READ  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } state_e;

  // Number of SCK periods in the frame for a command.
  function automatic logic [BITCNT_W-1:0] frame_len(input cmd_op_e op);
    case (op)
      CMD_WREN: return BITCNT_W'(8);
      CMD_RDSR: return BITCNT_W'(16);
      default:  return BITCNT_W'(24);
    endcase
  endfunction

  // Frame contents, MSB first and left-aligned in FRAME_W bits. Dummy
  // bits and anything past the frame end are zero so SI rests low.
  function automatic logic [FRAME_W-1:0] frame_bits(input cmd_op_e op,
                                                    input logic [7:0] addr,
                                                    input logic [7:0] wdata);
    case (op)
      CMD_WREN:  return {OP_WREN, 16'h0000};
      CMD_WRITE: return {OP_WRITE, addr, wdata};
      CMD_RDSR:  return {OP_RDSR, 16'h0000};
      default:   return {OP_READ, addr, 8'h00};
    endcase
  endfunction

  // Commands whose response carries the last received byte.
  function automatic logic op_returns_data(input cmd_op_e op);
    return (op == CMD_RDSR) || (op == CMD_READ);
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer
//   Loadable down-counter that times one SPI phase (SCK half-period or
//   CS gap). tick_o is high while the count is zero, i.e. in the last
//   cycle of an interval loaded with (length-1). It sits at zero when
//   not reloaded.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   load_i      load load_val_i this cycle (takes priority over counting)
//   load_val_i  interval length minus one
//   tick_o      interval ends this cycle
module spi_phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_eeprom_master.sv
// spi_eeprom_master
//   SPI mode-0 master issuing complete 25LC020A EEPROM transactions
//   (WREN, WRITE, RDSR, READ), one command at a time.
// Parameters:
//   CLK_DIV  CLK cycles per SCK half-period (>=1)
//   CS_GAP   minimum CLK cycles CS_N stays high between frames (>=1)
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   CMD_VALID/CMD_READY      request handshake
//   CMD_OP/ADDR/WDATA        command fields, latched on accept
//   RSP_VALID/RSP_DATA       one-cycle completion pulse and read byte
//   BUSY                     frame or CS gap in progress
//   SCK, CS_N, SI, SO        EEPROM serial pins
//   WP_N, HOLD_N             tied inactive (high)
module spi_eeprom_master #(
  parameter int CLK_DIV = 10,
  parameter int CS_GAP  = 50
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [7:0] CMD_ADDR,
  input  logic [7:0] CMD_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       SCK,
  output logic       CS_N,
  output logic       SI,
  input  logic       SO,
  output logic       WP_N,
  output logic       HOLD_N
);

  import spi_eeprom_pkg::*;

  // One timer serves both interval kinds, so size it for the longer one.
  localparam int TMR_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [BITCNT_W-1:0] bits_q, bits_d;      // SCK rises still to come
  logic [7:0]          rx_q, rx_d;
  logic [7:0]          rsp_data_q, rsp_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  cmd_op_e             op_q, op_d;

  logic                accept;
  logic                in_frame;
  logic                tick;
  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;

  assign accept   = CMD_VALID && (state_q == ST_IDLE);
  assign in_frame = (state_q == ST_SETUP) || (state_q == ST_HIGH) ||
                    (state_q == ST_LOW);

  // Reload on accept and at every phase boundary inside the frame; the
  // length depends on the phase being entered. GAP runs out to zero and
  // the counter then rests there through IDLE.
  assign tmr_load = accept || (in_frame && tick);
  assign tmr_val  = (state_d == ST_GAP) ? TMR_W'(CS_GAP - 1)
                                        : TMR_W'(CLK_DIV - 1);

  spi_phase_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_o     (tick)
  );

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (tick)   state_d = ST_HIGH;
      ST_HIGH:  if (tick)   state_d = ST_LOW;
      ST_LOW:   if (tick)   state_d = (bits_q == '0) ? ST_GAP : ST_HIGH;
      ST_GAP:   if (tick)   state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------
  always_comb begin
    CMD_READY = (state_q == ST_IDLE);
    BUSY      = (state_q != ST_IDLE);
    SCK       = (state_q == ST_HIGH);
    CS_N      = !in_frame;
    SI        = in_frame ? tx_q[FRAME_W-1] : 1'b0;
    RSP_VALID = rsp_valid_q;
    RSP_DATA  = rsp_data_q;
    WP_N      = 1'b1;
    HOLD_N    = 1'b1;
  end

  // ---------------------------------------------------------------
  // Datapath: shift registers, bit counter, response
  // ---------------------------------------------------------------
  always_comb begin
    tx_d        = tx_q;
    bits_d      = bits_q;
    rx_d        = rx_q;
    op_d        = op_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    if (accept) begin
      op_d   = cmd_op_e'(CMD_OP);
      tx_d   = frame_bits(cmd_op_e'(CMD_OP), CMD_ADDR, CMD_WDATA);
      bits_d = frame_len(cmd_op_e'(CMD_OP));
    end

    // Last HIGH cycle: sample SO, and advance SI so the next bit appears
    // as SCK falls, a full half-period ahead of the next rise.
    if ((state_q == ST_HIGH) && tick) begin
      rx_d   = {rx_q[6:0], SO};
      tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
      bits_d = bits_q - BITCNT_W'(1);
    end

    // Leaving the final LOW: report completion as GAP is entered.
    if ((state_q == ST_LOW) && tick && (bits_q == '0)) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = op_returns_data(op_q) ? rx_q : 8'h00;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_q        <= '0;
      bits_q      <= '0;
      rx_q        <= '0;
      op_q        <= CMD_WREN;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      tx_q        <= tx_d;
      bits_q      <= bits_d;
      rx_q        <= rx_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_spi_eeprom_master.sv
// tb_spi_eeprom_master
//   Drives spi_eeprom_master against a pin-level 25LC020A model and a
//   spec-level reference (byte array + write-enable latch).
module tb_spi_eeprom_master;

  localparam int D  = 10;    // CLK_DIV
  localparam int G  = 50;    // CS_GAP
  localparam int WT = 1500;  // model write-cycle time in CLK cycles

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic [1:0] CMD_OP = 2'd0;
  logic [7:0] CMD_ADDR = 8'h00;
  logic [7:0] CMD_WDATA = 8'h00;
  logic       SO = 1'b0;
  logic       CMD_READY, RSP_VALID, BUSY, SCK, CS_N, SI, WP_N, HOLD_N;
  logic [7:0] RSP_DATA;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;

  spi_eeprom_master #(.CLK_DIV(D), .CS_GAP(G)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY),
    .SCK(SCK), .CS_N(CS_N), .SI(SI), .SO(SO), .WP_N(WP_N), .HOLD_N(HOLD_N)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- spec-level frame description ----------------
  function automatic logic [23:0] exp_frame(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] d);
    case (op)
      2'd0:    return 24'h000006;
      2'd1:    return {8'h02, a, d};
      2'd2:    return 24'h000500;
      default: return {8'h03, a, 8'h00};
    endcase
  endfunction

  function automatic int exp_len(input logic [1:0] op);
    case (op)
      2'd0:    return 8;
      2'd2:    return 16;
      default: return 24;
    endcase
  endfunction

  // ---------------- reference and pin model state ----------------
  logic [7:0]  ref_mem [256];
  logic        ref_wel = 1'b0;
  logic [7:0]  mem [256];
  logic        wel = 1'b0, wip = 1'b0;
  int          wip_cnt = 0;
  logic [7:0]  w_addr = 8'h00, w_data = 8'h00;
  logic        sck_p = 1'b0, cs_p = 1'b1, si_p = 1'b0;
  int          si_run = 0;
  int          rx_bits = 0;
  logic [23:0] rx_sh = 24'h0;
  logic [7:0]  out_byte = 8'h00;
  logic        out_act = 1'b0;
  int          cs_low = 0, cs_high = 1000;
  int          rsp_cnt = 0;
  logic        abort_exp = 1'b0;
  logic [23:0] exp_fq[$];
  int          exp_nq[$];
  logic [7:0]  out_q[$];

  // 25LC020A pin model, evaluated on pin values of the cycle just ended.
  always @(posedge CLK) begin : pin_model
    int run_n;
    logic [23:0] ef;
    int en;
    if (wip) begin
      wip_cnt--;
      if (wip_cnt == 0) begin
        mem[w_addr] = w_data;
        wip = 1'b0;
        wel = 1'b0;
      end
    end
    if (RSP_VALID) rsp_cnt++;
    run_n = (SI === si_p) ? si_run + 1 : 0;
    if (CS_N == 1'b0) begin
      if (cs_p) begin
        chk("cs_gap_min", 32'(cs_high >= G), 32'd1);
        rx_bits = 0; rx_sh = 24'h0; out_act = 1'b0; cs_low = 0;
      end
      cs_low++;
      if (SCK && !sck_p) begin
        chk("si_stable_before_rise", 32'(run_n >= D), 32'd1);
        rx_sh = {rx_sh[22:0], SI};
        rx_bits++;
        if (rx_bits == 8 && rx_sh[7:0] == 8'h05) begin
          out_byte = {6'b0, wel, wip}; out_act = 1'b1; out_q.push_back(out_byte);
        end
        if (rx_bits == 16 && rx_sh[15:8] == 8'h03) begin
          out_byte = mem[rx_sh[7:0]]; out_act = 1'b1; out_q.push_back(out_byte);
        end
      end
      if (!SCK && sck_p && out_act) begin
        SO <= out_byte[7];
        out_byte = {out_byte[6:0], 1'b0};
      end
    end else if (!cs_p) begin
      SO <= 1'b0;
      cs_high = 0;
      if (abort_exp) begin
        chk("abort_sck_rises", 32'(rx_bits), 32'd12);
        abort_exp = 1'b0;
      end else if (exp_fq.size() == 0) begin
        chk("unexpected_frame", 32'd0, 32'd1);
      end else begin
        ef = exp_fq.pop_front();
        en = exp_nq.pop_front();
        chk("sck_rises", 32'(rx_bits), 32'(en));
        chk("si_frame", 32'(rx_sh), 32'(ef));
        chk("cs_low_len", 32'(cs_low), 32'((2 * en + 1) * D));
      end
      // EEPROM acts only on complete frames.
      if (rx_bits == 8 && rx_sh[7:0] == 8'h06) wel = 1'b1;
      if (rx_bits == 24 && rx_sh[23:16] == 8'h02 && wel && !wip) begin
        wip = 1'b1; wip_cnt = WT; w_addr = rx_sh[15:8]; w_data = rx_sh[7:0];
      end
    end
    if (CS_N) cs_high++;
    sck_p = SCK; cs_p = CS_N; si_p = SI; si_run = run_n;
  end

  // ---------------- stimulus tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic hold, input logic track);
    int k;
    if (track) begin
      exp_fq.push_back(exp_frame(op, a, d));
      exp_nq.push_back(exp_len(op));
    end
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_ADDR = a; CMD_WDATA = d;
    k = 0;
    while (!CMD_READY && k < 5000) begin @(negedge CLK); k++; end
    if (k >= 5000) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    acc_cyc = cyc;
    if (!hold) CMD_VALID = 1'b0;
  endtask

  task automatic wait_rsp(output logic [7:0] r);
    int k;
    k = 0;
    @(negedge CLK);
    while (!RSP_VALID && k < 3000) begin @(negedge CLK); k++; end
    if (k >= 3000) chk("rsp_timeout", 32'd0, 32'd1);
    r = RSP_DATA;
    @(negedge CLK);
    chk("rsp_one_cycle", 32'(RSP_VALID), 32'd0);
    chk("rsp_data_hold", 32'(RSP_DATA), 32'(r));
  endtask

  // Issue, wait and check the response against the reference rules.
  task automatic run(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] r);
    logic [7:0] e;
    issue(op, a, d, 1'b0, 1'b1);
    if (op == 2'd0) ref_wel = 1'b1;
    if (op == 2'd1 && ref_wel) begin ref_mem[a] = d; ref_wel = 1'b0; end
    wait_rsp(r);
    if (op < 2'd2) chk("rsp_zero", 32'(r), 32'd0);
    else if (out_q.size() == 0) chk("rsp_no_model_byte", 32'd0, 32'd1);
    else begin
      e = out_q.pop_front();
      chk("rsp_vs_model", 32'(r), 32'(e));
    end
  endtask

  task automatic poll_wip();
    logic [7:0] r;
    int n;
    n = 0;
    do begin run(2'd2, 8'h00, 8'h00, r); n++; end while (r[0] && n < 20);
    chk("wip_clears", 32'(r[0]), 32'd0);
    chk("wel_after_write", 32'(r[1]), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    logic [7:0] a, b, d;
    int a1, rc;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end

    // reset values
    repeat (3) @(negedge CLK);
    chk("rst_cs_n", 32'(CS_N), 32'd1);
    chk("rst_sck", 32'(SCK), 32'd0);
    chk("rst_si", 32'(SI), 32'd0);
    chk("rst_ready", 32'(CMD_READY), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_data", 32'(RSP_DATA), 32'd0);
    chk("rst_wp_hold", 32'({WP_N, HOLD_N}), 32'd3);
    RESET = 1'b0;

    // WREN with first-frame timing: CS_N low in cycle 1, SCK rises at 1+D
    issue(2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    ref_wel = 1'b1;
    chk("c1_cs_n", 32'(CS_N), 32'd0);
    chk("c1_si_msb", 32'(SI), 32'd0);
    chk("c1_busy", 32'({BUSY, CMD_READY}), 32'd2);
    repeat (D - 1) begin @(posedge CLK); #1; end
    chk("sck_low_cycle_D", 32'(SCK), 32'd0);
    @(posedge CLK); #1;
    chk("sck_rise_cycle_1pD", 32'(SCK), 32'd1);
    wait_rsp(r);
    chk("wren_rsp", 32'(r), 32'd0);

    // WRITE 0xFE <- 0xCB, then RDSR straight away sees WIP and WEL
    run(2'd1, 8'hFE, 8'hCB, r);
    run(2'd2, 8'h00, 8'h00, r);
    chk("rdsr_during_write", 32'(r), 32'h03);
    poll_wip();
    run(2'd3, 8'hFE, 8'h00, r);
    chk("read_fe", 32'(r), 32'hCB);

    // back-to-back: CMD_VALID held from RDSR into READ
    issue(2'd2, 8'h00, 8'h00, 1'b1, 1'b1);
    a1 = acc_cyc;
    CMD_OP = 2'd3; CMD_ADDR = 8'hFE;
    exp_fq.push_back(exp_frame(2'd3, 8'hFE, 8'h00));
    exp_nq.push_back(exp_len(2'd3));
    wait_rsp(r);
    chk("b2b_rdsr", 32'(r), 32'h00);
    if (out_q.size() != 0) void'(out_q.pop_front());
    issue(2'd3, 8'hFE, 8'h00, 1'b0, 1'b0);
    chk("b2b_spacing", 32'(acc_cyc - a1), 32'(33 * D + G + 1));
    wait_rsp(r);
    chk("b2b_read", 32'(r), 32'hCB);
    if (out_q.size() != 0) void'(out_q.pop_front());

    // randomized write/read traffic, WREN sometimes omitted
    for (int it = 0; it < 5; it++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) run(2'd0, 8'h00, 8'h00, r);
      run(2'd1, a, d, r);
      poll_wip();
      run(2'd3, a, 8'h00, r);
      chk("rand_read_written", 32'(r), 32'(ref_mem[a]));
      run(2'd3, b, 8'h00, r);
      chk("rand_read_other", 32'(r), 32'(ref_mem[b]));
    end

    // RESET at the 12th SCK rise of a WRITE to 0xFE
    run(2'd0, 8'h00, 8'h00, r);
    run(2'd3, 8'hFE, 8'h00, r);
    chk("pre_abort_read", 32'(r), 32'(ref_mem[8'hFE]));
    abort_exp = 1'b1;
    issue(2'd1, 8'hFE, 8'h5A, 1'b0, 1'b0);
    rc = 0;
    while (rx_bits != 12 && rc < 2000) begin @(negedge CLK); rc++; end
    if (rc >= 2000) chk("abort_rise_timeout", 32'd0, 32'd1);
    RESET = 1'b1;
    rc = rsp_cnt;
    @(posedge CLK); #1;
    chk("abort_cs_n", 32'(CS_N), 32'd1);
    chk("abort_sck", 32'(SCK), 32'd0);
    chk("abort_si", 32'(SI), 32'd0);
    chk("abort_idle", 32'({CMD_READY, BUSY}), 32'd2);
    RESET = 1'b0;
    repeat (100) @(posedge CLK);
    #1;
    chk("abort_no_rsp", 32'(rsp_cnt), 32'(rc));
    run(2'd3, 8'hFE, 8'h00, r);
    chk("read_after_abort", 32'(r), 32'(ref_mem[8'hFE]));
    chk("read_after_abort_old", 32'(r), 32'hCB);

    repeat (10) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
